player_ctrl: RTL and testbench
==============================

// Module: player_ctrl
// PURPOSE
//  Upstream stage of the VGA renderer: turns UART/keyboard ASCII key events into the heart position.
//  Drives playerPos {x[15:8], y[7:0]}, relative to the play-area interior; the renderer adds +220/+140.
//  Moves once per frame on the vsync edge. Keeps the 17x17 heart inside the 200x200 arena border.
// PARAMETERS
//  STEP        2    pixels moved per frame while a direction is active
//  HOLD_FRAMES 8    frames a single key press keeps the heart moving (key-repeat emulation)
//  MIN_POS     9    lowest legal coordinate (heart edge clears inner border at 220/140)
//  MAX_POS     191  highest legal coordinate
//  START_POS   100  x and y after reset (arena centre)
// PORTS
//  clk        in   1   system clock (100 MHz, same clock as renderer)
//  reset      in   1   synchronous, active-high
//  vsync      in   1   renderer vsync (active-high during retrace)
//  key_valid  in   1   one-cycle strobe: key_code holds a new key
//  key_code   in   8   ASCII: 'w' 8'h77 up, 's' 8'h73 down, 'a' 8'h61 left, 'd' 8'h64 right, ' ' 8'h20 stop
//  playerPos  out  16  {x, y}, unsigned 8-bit each
//  isRender   out  1   one-cycle pulse, the cycle after playerPos is updated for a frame
//  moving     out  1   high while a direction is active (state MOVE)
// BEHAVIOUR
//  Reset (sync, dominates all inputs):
//   - playerPos = {START_POS, START_POS}; isRender = 0; moving = 0.
//   - State = IDLE; hold_cnt = 0; dir = none; vsync_q = 0.
//  Frame tick: frame_tick = vsync & ~vsync_q, i.e. rising edge of vsync (1 cycle). No tick on the first cycle after reset if vsync is already high.
//  FSM IDLE:
//   - Valid direction key -> MOVE, dir = key, hold_cnt = HOLD_FRAMES.
//   - Space or unknown code -> ignored.
//  FSM MOVE:
//   - Direction key (same or other) -> dir replaced, hold_cnt reloaded to HOLD_FRAMES.
//   - Space -> IDLE, dir cleared; no further moves.
//   - On frame_tick: apply one step along dir, then hold_cnt -= 1. When it reaches 0 -> IDLE.
//   - A key pressed with no further input produces exactly HOLD_FRAMES moves.
//  Simultaneous key_valid and frame_tick:
//   - The key is applied first; that same frame moves with the new dir and the reloaded count.
//   - Space + tick -> no move.
//  Arithmetic:
//   - Computed in 9 bits, then clamped to [MIN_POS, MAX_POS]. No wrap-around ever.
//   - At a wall the coordinate holds, and hold_cnt still decrements.
//  playerPos registers update on the tick cycle (visible the next cycle). isRender pulses the cycle after every frame_tick in MOVE, including clamped or no-change moves.
//  Mid-frame reset: position returns to START_POS immediately; the pending move is discarded.
// CONFIGURATION
//  PLAYER_DIAG_EN defined:
//   - 'q' 8'h71, 'e' 8'h65, 'z' 8'h7A, 'c' 8'h63 select diagonals UL/UR/DL/DR.
//   - Each axis steps STEP and is clamped independently: at a wall the other axis keeps sliding.
//  Undefined: those codes are ignored like any unknown key (IDLE stays, MOVE unchanged).
// STRUCTURE
//  Package player_pkg:
//   - ASCII key constants.
//   - Direction enum: NONE,U,D,L,R[,UL,UR,DL,DR].
//   - MIN_POS/MAX_POS/START_POS defaults.
//   - Arena offsets 220/140.
//  Sub-module frame_tick_gen: vsync rising-edge detector, sync reset, 1-cycle frame_tick out.
//  Decode, FSM and clamp datapath in player_ctrl.
// TESTING
//  1. Reset, no keys, 5 vsync pulses -> playerPos = 16'h6464, isRender never pulses, moving = 0.
//  2. 'd' then 10 frames, STEP=2, HOLD=8 -> x = 100 -> 116 after 8 frames, then holds.
//     isRender pulses 8 times; moving drops after frame 8.
//  3. 'a' repeated every frame from x=100 -> x decreases to 9 and stays 9 (no wrap to 255).
//     playerPos[15:8] never < 9.
//  4. 'w' then ' ' after 3 frames -> y = 94, then frozen. Key + frame_tick in the same cycle:
//     new dir used that frame.
//  5. Assert reset mid-MOVE, during the tick cycle -> next cycle playerPos = 16'h6464,
//     moving = 0, isRender = 0.
//  6. PLAYER_DIAG_EN: 'c' from (190,100) -> x clamps at 191, y keeps +2/frame.
//     Without the macro, 'c' -> no motion.

Source files
------------

// File: rtl/player_pkg.sv
// Shared constants, types and helpers for the heart-position controller.
// Contents: ASCII key codes, direction enum, position limits and arena
// offsets, and a single-axis step-and-clamp helper.
package player_pkg;

    localparam logic [7:0] KEY_UP    = 8'h77;  // 'w'
    localparam logic [7:0] KEY_DOWN  = 8'h73;  // 's'
    localparam logic [7:0] KEY_LEFT  = 8'h61;  // 'a'
    localparam logic [7:0] KEY_RIGHT = 8'h64;  // 'd'
    localparam logic [7:0] KEY_STOP  = 8'h20;  // ' '
    localparam logic [7:0] KEY_UL    = 8'h71;  // 'q'
    localparam logic [7:0] KEY_UR    = 8'h65;  // 'e'
    localparam logic [7:0] KEY_DL    = 8'h7A;  // 'z'
    localparam logic [7:0] KEY_DR    = 8'h63;  // 'c'

    localparam int unsigned MIN_POS     = 9;
    localparam int unsigned MAX_POS     = 191;
    localparam int unsigned START_POS   = 100;
    localparam int unsigned ARENA_X_OFF = 220;
    localparam int unsigned ARENA_Y_OFF = 140;

    typedef enum logic [3:0] {
        DIR_NONE,
        DIR_U,
        DIR_D,
        DIR_L,
        DIR_R,
        DIR_UL,
        DIR_UR,
        DIR_DL,
        DIR_DR
    } dir_e;

    // One axis step in 9 bits, saturating at [lo, hi]; never wraps.
    function automatic logic [7:0] step_axis(
        input logic [7:0] pos,
        input logic       dec,
        input logic       inc,
        input logic [7:0] step,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        logic [8:0] sum;
        sum = {1'b0, pos};
        if (inc) begin
            sum = {1'b0, pos} + {1'b0, step};
        end else if (dec) begin
            sum = ({1'b0, pos} < ({1'b0, lo} + {1'b0, step})) ? {1'b0, lo}
                                                               : {1'b0, pos} - {1'b0, step};
        end
        if (sum > {1'b0, hi}) begin
            sum = {1'b0, hi};
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/player_ctrl_frame_tick_gen.sv
// frame_tick_gen: vsync rising-edge detector.
// Ports: clk, reset (sync, active-high), vsync_i (renderer vsync),
//        frame_tick_o (combinational one-cycle pulse on a vsync rising edge).
// armed_q masks the first cycle after reset so a vsync that is already high
// when reset releases does not count as an edge.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync_i,
    output logic frame_tick_o
);

    logic vsync_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            armed_q <= 1'b1;
        end
    end

    assign frame_tick_o = vsync_i & ~vsync_q & armed_q;

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: turns ASCII key events into the heart position, one step per frame.
// Ports: clk, reset (sync, active-high), vsync, key_valid, key_code[7:0],
//        playerPos[15:0] = {x, y} inside the arena, isRender (pulse after a frame move),
//        moving (a direction is active).
// Build option: define PLAYER_DIAG_EN to accept 'q'/'e'/'z'/'c' diagonal keys.
module player_ctrl
    import player_pkg::*;
#(
    parameter int unsigned STEP        = 2,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic [15:0] playerPos,
    output logic        isRender,
    output logic        moving
);

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MOVE = 1'b1;

    localparam logic [7:0]        STEP_B    = 8'(STEP);
    localparam logic [7:0]        MIN_B     = 8'(MIN_POS);
    localparam logic [7:0]        MAX_B     = 8'(MAX_POS);
    localparam logic [7:0]        START_B   = 8'(START_POS);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic              frame_tick;
    logic [0:0]        state_q, state_d;
    dir_e              dir_q, dir_d;
    dir_e              key_dir;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic              render_q, render_d;
    logic              x_inc, x_dec, y_inc, y_dec;

    frame_tick_gen u_tick (
        .clk          (clk),
        .reset        (reset),
        .vsync_i      (vsync),
        .frame_tick_o (frame_tick)
    );

    // Key decode; space and unknown codes map to DIR_NONE.
    always_comb begin
        key_dir = DIR_NONE;
        case (key_code)
            KEY_UP:    key_dir = DIR_U;
            KEY_DOWN:  key_dir = DIR_D;
            KEY_LEFT:  key_dir = DIR_L;
            KEY_RIGHT: key_dir = DIR_R;
`ifdef PLAYER_DIAG_EN
            KEY_UL:    key_dir = DIR_UL;
            KEY_UR:    key_dir = DIR_UR;
            KEY_DL:    key_dir = DIR_DL;
            KEY_DR:    key_dir = DIR_DR;
`else
`endif
            default:   key_dir = DIR_NONE;
        endcase
    end

    // Next state: the key is applied first, so a tick in the same cycle
    // already moves with the new direction and the reloaded hold count.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        x_d      = x_q;
        y_d      = y_q;
        render_d = 1'b0;
        x_inc    = 1'b0;
        x_dec    = 1'b0;
        y_inc    = 1'b0;
        y_dec    = 1'b0;

        if (key_valid) begin
            if (key_dir != DIR_NONE) begin
                state_d = S_MOVE;
                dir_d   = key_dir;
                hold_d  = HOLD_INIT;
            end else if (key_code == KEY_STOP && state_q == S_MOVE) begin
                state_d = S_IDLE;
                dir_d   = DIR_NONE;
                hold_d  = '0;
            end
        end

        // Screen y grows downward, so "up" decrements y.
        case (dir_d)
            DIR_U:   y_dec = 1'b1;
            DIR_D:   y_inc = 1'b1;
            DIR_L:   x_dec = 1'b1;
            DIR_R:   x_inc = 1'b1;
            DIR_UL:  begin x_dec = 1'b1; y_dec = 1'b1; end
            DIR_UR:  begin x_inc = 1'b1; y_dec = 1'b1; end
            DIR_DL:  begin x_dec = 1'b1; y_inc = 1'b1; end
            DIR_DR:  begin x_inc = 1'b1; y_inc = 1'b1; end
            default: ;
        endcase

        // Each axis clamps on its own; a blocked move still consumes a frame.
        if (frame_tick && state_d == S_MOVE) begin
            x_d      = step_axis(x_q, x_dec, x_inc, STEP_B, MIN_B, MAX_B);
            y_d      = step_axis(y_q, y_dec, y_inc, STEP_B, MIN_B, MAX_B);
            hold_d   = hold_d - HOLD_W'(1);
            render_d = 1'b1;
            if (hold_d == '0) begin
                state_d = S_IDLE;
                dir_d   = DIR_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_NONE;
            hold_q   <= '0;
            x_q      <= START_B;
            y_q      <= START_B;
            render_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            hold_q   <= hold_d;
            x_q      <= x_d;
            y_q      <= y_d;
            render_q <= render_d;
        end
    end

    assign playerPos = {x_q, y_q};
    assign isRender  = render_q;
    assign moving    = (state_q == S_MOVE);

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: a fixed vector table, directed
// multi-frame sequences, then random traffic against a behavioural model.
module tb_player_ctrl;

    localparam int STEP = 2;
    localparam int HOLD = 8;
    localparam int NTBL = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [15:0] playerPos;
    logic        isRender;
    logic        moving;

    player_ctrl #(
        .STEP        (STEP),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .key_valid (key_valid),
        .key_code  (key_code),
        .playerPos (playerPos),
        .isRender  (isRender),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int render_seen = 0;

    // Behavioural model: integer position, direction vector, frames left.
    int mx, my, mdx, mdy, mleft;
    bit mvprev, marmed, mrender;

    typedef struct {
        bit          rst;
        bit          vs;
        bit          kv;
        logic [7:0]  kc;
        logic [15:0] pos;
        bit          r;
        bit          m;
    } vec_t;

    vec_t tbl [NTBL];

    function automatic bit key_vec(input logic [7:0] k, output int dx, output int dy);
        dx = 0;
        dy = 0;
        case (k)
            8'h77: begin dy = -1; return 1'b1; end
            8'h73: begin dy =  1; return 1'b1; end
            8'h61: begin dx = -1; return 1'b1; end
            8'h64: begin dx =  1; return 1'b1; end
`ifdef PLAYER_DIAG_EN
            8'h71: begin dx = -1; dy = -1; return 1'b1; end
            8'h65: begin dx =  1; dy = -1; return 1'b1; end
            8'h7A: begin dx = -1; dy =  1; return 1'b1; end
            8'h63: begin dx =  1; dy =  1; return 1'b1; end
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic int clampi(input int v);
        if (v < 9)   return 9;
        if (v > 191) return 191;
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit vs, input bit kv, input logic [7:0] kc);
        bit tick;
        bit ok;
        int dx, dy;
        if (rst) begin
            mx = 100; my = 100; mdx = 0; mdy = 0; mleft = 0;
            mvprev = 1'b0; marmed = 1'b0; mrender = 1'b0;
            return;
        end
        tick    = vs && !mvprev && marmed;
        mvprev  = vs;
        marmed  = 1'b1;
        mrender = 1'b0;
        if (kv) begin
            ok = key_vec(kc, dx, dy);
            if (ok) begin
                mdx = dx; mdy = dy; mleft = HOLD;
            end else if (kc == 8'h20) begin
                mleft = 0;
            end
        end
        if (tick && mleft > 0) begin
            mx = clampi(mx + mdx * STEP);
            my = clampi(my + mdy * STEP);
            mleft--;
            mrender = 1'b1;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic apply(input bit rst, input bit vs, input bit kv, input logic [7:0] kc);
        reset     = rst;
        vsync     = vs;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(rst, vs, kv, kc);
        @(negedge clk);
        if (isRender === 1'b1) render_seen++;
    endtask

    task automatic cyc(input bit rst, input bit vs, input bit kv, input logic [7:0] kc, input string name);
        logic [15:0] epos;
        apply(rst, vs, kv, kc);
        epos = {8'(mx), 8'(my)};
        n_vec++;
        if ({playerPos, isRender, moving} !== {epos, mrender, (mleft > 0)}) begin
            n_err++;
            $display("FAIL %s: got pos=%h isRender=%b moving=%b, expected pos=%h isRender=%b moving=%b",
                     name, playerPos, isRender, moving, epos, mrender, (mleft > 0));
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic frame(input string name);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, name);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, name);
    endtask

    initial begin
        int minx;
        bit vs_r;
        logic [7:0] picks [10];
        logic [15:0] diag_exp;

        reset = 1'b1; vsync = 1'b0; key_valid = 1'b0; key_code = 8'h00;

        //           rst   vs    kv    code   pos       r     m
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h64, 16'h6464, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6664, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6664, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h77, 16'h6664, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h61, 16'h6464, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h20, 16'h6464, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h78, 16'h6464, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h73, 16'h6466, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h63, 16'h6466, 1'b0, 1'b1};
`ifdef PLAYER_DIAG_EN
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6668, 1'b1, 1'b1};
`else
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6468, 1'b1, 1'b1};
`endif
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 8'h64, 16'h6464, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 8'h64, 16'h6464, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h6464, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h6664, 1'b1, 1'b1};

        for (int i = 0; i < NTBL; i++) begin
            apply(tbl[i].rst, tbl[i].vs, tbl[i].kv, tbl[i].kc);
            n_vec++;
            if ({playerPos, isRender, moving} !== {tbl[i].pos, tbl[i].r, tbl[i].m}) begin
                n_err++;
                $display("FAIL vec[%0d]: got pos=%h isRender=%b moving=%b, expected pos=%h isRender=%b moving=%b",
                         i, playerPos, isRender, moving, tbl[i].pos, tbl[i].r, tbl[i].m);
            end
        end

        // Idle frames: no movement, no render pulses.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "idle_rst");
        render_seen = 0;
        repeat (5) frame("idle_frame");
        check_val("idle_renders", render_seen, 0);
        check_val("idle_pos", int'(playerPos), 16'h6464);

        // One 'd' press gives exactly HOLD moves.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "hold_rst");
        cyc(1'b0, 1'b0, 1'b1, 8'h64, "hold_key");
        render_seen = 0;
        repeat (10) frame("hold_frame");
        check_val("hold_x", int'(playerPos[15:8]), 116);
        check_val("hold_renders", render_seen, 8);
        check_val("hold_moving", int'(moving), 0);

        // Left wall: saturate at 9, never wrap.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "wall_rst");
        minx = 255;
        repeat (60) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h61, "wall_key");
            cyc(1'b0, 1'b1, 1'b0, 8'h00, "wall_tick");
            if (int'(playerPos[15:8]) < minx) minx = int'(playerPos[15:8]);
        end
        check_val("wall_x", int'(playerPos[15:8]), 9);
        check_val("wall_min_x", minx, 9);

        // Up for three frames, then stop.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "stop_rst");
        cyc(1'b0, 1'b0, 1'b1, 8'h77, "stop_key_w");
        repeat (3) frame("stop_move");
        cyc(1'b0, 1'b0, 1'b1, 8'h20, "stop_key_sp");
        repeat (3) frame("stop_frozen");
        check_val("stop_y", int'(playerPos[7:0]), 94);
        check_val("stop_moving", int'(moving), 0);
        // Space together with a tick: no move.
        cyc(1'b0, 1'b0, 1'b1, 8'h73, "sptick_key");
        cyc(1'b0, 1'b1, 1'b1, 8'h20, "sptick_tick");
        check_val("sptick_y", int'(playerPos[7:0]), 94);

        // Reset asserted on the tick cycle mid-move.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "midrst_rst");
        cyc(1'b0, 1'b0, 1'b1, 8'h64, "midrst_key");
        repeat (2) frame("midrst_move");
        cyc(1'b1, 1'b1, 1'b0, 8'h00, "midrst_tick");
        check_val("midrst_pos", int'(playerPos), 16'h6464);
        check_val("midrst_moving", int'(moving), 0);
        check_val("midrst_render", int'(isRender), 0);

        // Diagonal from (190,100): x saturates, y keeps sliding.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "diag_rst");
        repeat (45) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h64, "diag_walk_key");
            cyc(1'b0, 1'b1, 1'b0, 8'h00, "diag_walk_tick");
        end
        check_val("diag_start_x", int'(playerPos[15:8]), 190);
        cyc(1'b0, 1'b0, 1'b1, 8'h20, "diag_stop");
        cyc(1'b0, 1'b0, 1'b1, 8'h63, "diag_key_c");
        repeat (3) frame("diag_frame");
`ifdef PLAYER_DIAG_EN
        diag_exp = 16'hBF6A;
`else
        diag_exp = 16'hBE64;
`endif
        check_val("diag_pos", int'(playerPos), int'(diag_exp));

        // Random traffic against the model.
        picks[0] = 8'h77; picks[1] = 8'h73; picks[2] = 8'h61; picks[3] = 8'h64;
        picks[4] = 8'h20; picks[5] = 8'h71; picks[6] = 8'h65; picks[7] = 8'h7A;
        picks[8] = 8'h63; picks[9] = 8'h00;
        vs_r = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "rand_rst");
        repeat (4000) begin
            logic [7:0] kc;
            bit rst, kv;
            if ($urandom_range(0, 2) == 0) vs_r = ~vs_r;
            rst = ($urandom_range(0, 299) == 0);
            kv  = ($urandom_range(0, 4) == 0);
            kc  = picks[$urandom_range(0, 9)];
            if (kc == 8'h00) kc = 8'($urandom_range(0, 255));
            cyc(rst, vs_r, kv, kc, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
